bloco_despacho: RTL and testbench

- Upstream dispatch stage for the bloco_controle/datapath core.
- Accepts operands from a valid/ready producer and buffers them in a small FIFO.
- Launches the core with a one-cycle start pulse per operand and captures the result (S) when the core raises valid.
- Presents each result to a valid/ready consumer; a watchdog aborts a core run that never completes.

---
 rtl/bloco_despacho_pkg.sv | 13 +
 rtl/bloco_despacho_if.sv | 37 +++
 rtl/bloco_despacho_fifo.sv | 49 ++++
 rtl/bloco_despacho.sv | 104 ++++++++++
 tb/tb_bloco_despacho.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bloco_despacho_pkg.sv
// Shared definitions for the dispatch stage: FSM encoding and default width.
package bloco_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } estado_t;

endpackage

// File: rtl/bloco_despacho_if.sv
// Producer, core and consumer handshake channels of the dispatch stage.
// slave is the dispatch block's view, master is the surrounding system's view.
interface bloco_despacho_if #(
    parameter int W = bloco_pkg::W_DEF
);
    // producer -> dispatch
    logic         in_valid;
    logic [W-1:0] in_x;
    logic         in_ready;
    // dispatch <-> core
    logic         start;
    logic [W-1:0] x_out;
    logic         core_valid;
    logic [W-1:0] core_s;
    // dispatch -> consumer
    logic         out_valid;
    logic [W-1:0] out_s;
    logic         out_ready;

    modport slave (
        input  in_valid, in_x,
        output in_ready,
        output start, x_out,
        input  core_valid, core_s,
        output out_valid, out_s,
        input  out_ready
    );

    modport master (
        output in_valid, in_x,
        input  in_ready,
        input  start, x_out,
        output core_valid, core_s,
        input  out_valid, out_s,
        output out_ready
    );
endinterface

// File: rtl/bloco_despacho_fifo.sv
// Small synchronous operand FIFO. Push is refused when full, pop when empty.
// Pointers are log2(DEPTH) bits so they wrap naturally (DEPTH is a power of 2).
module fifo_operandos #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // storage: no reset needed, contents are only read behind a valid count
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= din;
    end

    // pointers and occupancy; a simultaneous push and pop leaves count alone
    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/bloco_despacho.sv
// Dispatch stage: buffers operands, launches the core once per operand,
// captures its result and hands it to the consumer. A watchdog drops an
// operand whose core run never completes and raises a sticky err.
module bloco_despacho
    import bloco_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    bloco_despacho_if.slave        bus,
    output logic                   err,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] count
);
    localparam int TW = $clog2(TIMEOUT);

    estado_t       est, est_nx;
    logic [TW-1:0] timer;
    logic          full, empty;
    logic          push, pop;
    logic [W-1:0]  head;
    logic          wait_ok, wait_to;
    logic          start_r, out_valid_r;
    logic [W-1:0]  x_out_r, out_s_r;

    // in_ready depends only on full: a pop in the same cycle does not open a slot
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;

    // WAIT exits: core result (has priority) or watchdog expiry
    assign wait_ok = (est == ST_WAIT) && bus.core_valid;
    assign wait_to = (est == ST_WAIT) && !bus.core_valid && (timer == TW'(TIMEOUT - 1));
    assign pop     = wait_ok || wait_to;

    fifo_operandos #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (bus.in_x),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // state register
    always_ff @(posedge clock) begin
        if (!reset) est <= ST_IDLE;
        else        est <= est_nx;
    end

    // next-state logic
    always_comb begin
        est_nx = est;
        case (est)
            ST_IDLE:   if (!empty) est_nx = ST_LAUNCH;
            ST_LAUNCH: est_nx = ST_WAIT;
            ST_WAIT: begin
                if (wait_ok)      est_nx = ST_HOLD;
                else if (wait_to) est_nx = ST_IDLE;
            end
            ST_HOLD:   if (bus.out_ready) est_nx = ST_IDLE;
            default:   est_nx = ST_IDLE;
        endcase
    end

    // registered outputs: start/out_valid follow the state being entered
    always_ff @(posedge clock) begin
        if (!reset) begin
            start_r     <= 1'b0;
            out_valid_r <= 1'b0;
            x_out_r     <= '0;
            out_s_r     <= '0;
        end else begin
            start_r     <= (est_nx == ST_LAUNCH);
            out_valid_r <= (est_nx == ST_HOLD);
            if ((est == ST_IDLE) && !empty) x_out_r <= head;
            if (wait_ok)                    out_s_r <= bus.core_s;
        end
    end

    // watchdog timer: cleared at launch, counts WAIT cycles, held at exit so it never wraps
    always_ff @(posedge clock) begin
        if (!reset)                        timer <= '0;
        else if (est == ST_LAUNCH)         timer <= '0;
        else if ((est == ST_WAIT) && !pop) timer <= timer + 1'b1;
    end

    // sticky error: a timeout in the same cycle as err_clr keeps err set
    always_ff @(posedge clock) begin
        if (!reset)       err <= 1'b0;
        else if (wait_to) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

    assign bus.start     = start_r;
    assign bus.x_out     = x_out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_s     = out_s_r;
endmodule

// File: tb/tb_bloco_despacho.sv
// Directed bench for bloco_despacho: a vector table of single transactions
// plus hand-written sequences for fill, timeout, backpressure and reset.
module tb_bloco_despacho;
    localparam int W       = 8;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 16;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       err_clr = 1'b0;
    logic       err;
    logic [1:0] count;

    bloco_despacho_if #(.W(W)) bus();

    bloco_despacho #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .err     (err),
        .err_clr (err_clr),
        .count   (count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] x;
        logic [7:0] s;
        int         lat;    // WAIT cycles before core_valid is raised
        int         hold;   // cycles the consumer stalls
        logic [7:0] exp_x;
        logic [7:0] exp_s;
        logic       exp_err;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push1(input logic [7:0] x);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (!bus.start && n < 10) begin
            tick();
            n++;
        end
        chk({nm, "_start_seen"}, bus.start, 1);
    endtask

    // run one launched/queued operand through the core and the consumer
    task automatic service(input string nm, input logic [7:0] ex, input logic [7:0] s,
                           input int lat, input int hold);
        wait_start(nm);
        chk({nm, "_x_out"}, bus.x_out, ex);
        repeat (lat) tick();
        bus.core_valid = 1'b1;
        bus.core_s     = s;
        tick();
        bus.core_valid = 1'b0;
        chk({nm, "_out_valid"}, bus.out_valid, 1);
        chk({nm, "_out_s"}, bus.out_s, s);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({nm, "_hold_valid"}, bus.out_valid, 1);
            chk({nm, "_hold_s"}, bus.out_s, s);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({nm, "_out_drop"}, bus.out_valid, 0);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_x       = '0;
        bus.core_valid = 1'b0;
        bus.core_s     = '0;
        bus.out_ready  = 1'b0;

        tbl[0] = '{x: 8'h2A, s: 8'h55, lat: 3,  hold: 0, exp_x: 8'h2A, exp_s: 8'h55, exp_err: 1'b0};
        tbl[1] = '{x: 8'hFF, s: 8'h00, lat: 1,  hold: 2, exp_x: 8'hFF, exp_s: 8'h00, exp_err: 1'b0};
        tbl[2] = '{x: 8'h00, s: 8'hFF, lat: 16, hold: 0, exp_x: 8'h00, exp_s: 8'hFF, exp_err: 1'b0};
        tbl[3] = '{x: 8'hA5, s: 8'h5A, lat: 7,  hold: 1, exp_x: 8'hA5, exp_s: 8'h5A, exp_err: 1'b0};
        tbl[4] = '{x: 8'h80, s: 8'h7F, lat: 15, hold: 0, exp_x: 8'h80, exp_s: 8'h7F, exp_err: 1'b0};

        // reset state
        repeat (3) tick();
        reset = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_start", bus.start, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_x_out", bus.x_out, 0);
        chk("rst_out_s", bus.out_s, 0);
        chk("rst_err", err, 0);

        // single operand with exact cycle timing: push in cycle 1, start in cycle 3
        push1(8'h2A);
        chk("t1_count", count, 1);
        chk("t1_start_c2", bus.start, 0);
        tick();
        chk("t1_start_c3", bus.start, 1);
        chk("t1_x_out", bus.x_out, 8'h2A);
        tick();
        chk("t1_start_c4", bus.start, 0);
        tick();
        tick();
        bus.core_valid = 1'b1;
        bus.core_s     = 8'h55;
        tick();
        bus.core_valid = 1'b0;
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_s", bus.out_s, 8'h55);
        chk("t1_count_pop", count, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t1_out_drop", bus.out_valid, 0);

        // vector table, includes core_valid on the watchdog's last cycle
        for (int v = 0; v < 5; v++) begin
            push1(tbl[v].x);
            service($sformatf("vec%0d", v), tbl[v].exp_x, tbl[v].s, tbl[v].lat, tbl[v].hold);
            chk($sformatf("vec%0d_s_val", v), bus.out_s, tbl[v].exp_s);
            chk($sformatf("vec%0d_err", v), err, tbl[v].exp_err);
        end

        // fill: 0x03 held off while full, results in order
        bus.in_valid = 1'b1;
        bus.in_x     = 8'h01;
        tick();
        bus.in_x = 8'h02;
        tick();
        bus.in_x = 8'h03;
        chk("fill_count2", count, 2);
        chk("fill_ready0", bus.in_ready, 0);
        repeat (3) begin
            tick();
            chk("fill_blocked", bus.in_ready, 0);
        end
        chk("fill_x_out1", bus.x_out, 8'h01);
        bus.core_valid = 1'b1;
        bus.core_s     = 8'h01;
        tick();
        bus.core_valid = 1'b0;
        chk("fill_pop_count", count, 1);
        chk("fill_r1", bus.out_s, 8'h01);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("fill_count_after3", count, 2);
        service("fill2", 8'h02, 8'h02, 1, 0);
        service("fill3", 8'h03, 8'h03, 2, 0);
        chk("fill_empty", count, 0);

        // consumer backpressure with a second operand queued
        push1(8'hC0);
        push1(8'hC1);
        wait_start("bp");
        chk("bp_x_out", bus.x_out, 8'hC0);
        tick();
        bus.core_valid = 1'b1;
        bus.core_s     = 8'hC3;
        tick();
        bus.core_valid = 1'b0;
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_count", count, 1);
        repeat (5) begin
            tick();
            chk("bp_hold_s", bus.out_s, 8'hC3);
            chk("bp_no_start", bus.start, 0);
            chk("bp_hold_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_drop", bus.out_valid, 0);
        service("bp2", 8'hC1, 8'h3C, 2, 0);

        // timeout: err appears only after the 16th WAIT cycle
        push1(8'h10);
        wait_start("to");
        repeat (TIMEOUT) tick();
        chk("to_err_pre", err, 0);
        chk("to_count_pre", count, 1);
        tick();
        chk("to_err", err, 1);
        chk("to_count", count, 0);
        chk("to_no_valid", bus.out_valid, 0);
        repeat (3) tick();
        chk("to_sticky", err, 1);
        chk("to_idle_no_start", bus.start, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_clr", err, 0);

        // timeout with err_clr held: set wins, then clear takes over
        err_clr = 1'b1;
        push1(8'h11);
        wait_start("to2");
        repeat (TIMEOUT + 1) tick();
        chk("to2_set_wins", err, 1);
        tick();
        chk("to2_cleared", err, 0);
        err_clr = 1'b0;

        // reset in WAIT with two operands buffered
        push1(8'h21);
        push1(8'h22);
        wait_start("rw");
        tick();
        chk("rw_count2", count, 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rw_count", count, 0);
        chk("rw_start", bus.start, 0);
        chk("rw_valid", bus.out_valid, 0);
        chk("rw_err", err, 0);
        chk("rw_ready", bus.in_ready, 1);
        bus.core_valid = 1'b1;
        bus.core_s     = 8'hEE;
        tick();
        bus.core_valid = 1'b0;
        chk("rw_late_valid", bus.out_valid, 0);
        tick();
        chk("rw_late_valid2", bus.out_valid, 0);
        chk("rw_out_s", bus.out_s, 0);
        chk("rw_no_start", bus.start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
